// File: rtl/piece_spawner.sv
// ---------------------------------------------------------------------------
// tetris_pkg: shared piece/rotation types for the game datapath.
//
// piece_spawner: supplies new pieces to the game executioner.
//   A 7-bag randomizer, indexed by a 16-bit Galois LFSR, fills a shallow
//   preview FIFO. The executioner pops the head with a one-cycle spawn_req.
//
// Ports:
//   game_clk        block clock
//   reset           synchronous, active-high reset
//   spawn_req       one-cycle pop of the FIFO head
//   entropy         XORed into LFSR bit 15 on every step
//   new_piece       FIFO head as a spawn-ready active piece (x=4, y=0, ROT_0)
//   piece_valid     FIFO non-empty
//   next_piece_type entry behind the head (0 if fewer than 2 entries)
//   queue_count     current FIFO occupancy
//   piece_count     accepted pops, wraps at 2^16
//   underflow       sticky: spawn_req seen while the FIFO was empty
// ---------------------------------------------------------------------------
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_type_t;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rotation_t;

  typedef struct packed {
    piece_type_t piece_type;
    logic [3:0]  x;
    logic [4:0]  y;
    rotation_t   rotation;
  } active_piece_t;

endpackage

module piece_spawner #(
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                      game_clk,
  input  logic                      reset,
  input  logic                      spawn_req,
  input  logic                      entropy,
  output tetris_pkg::active_piece_t new_piece,
  output logic                      piece_valid,
  output logic [2:0]                next_piece_type,
  output logic [2:0]                queue_count,
  output logic [15:0]               piece_count,
  output logic                      underflow
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  DEPTH_Q  = 3'(PREVIEW_DEPTH);
  localparam logic [3:0]  SPAWN_X  = 4'd4;
  localparam logic [4:0]  SPAWN_Y  = 5'd0;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [6:0]  used_reg, used_next;
  logic [2:0]  count_reg, count_next;
  logic [15:0] piece_count_reg, piece_count_next;
  logic        underflow_reg, underflow_next;
  logic [2:0]  fifo_reg  [PREVIEW_DEPTH];
  logic [2:0]  fifo_next [PREVIEW_DEPTH];

  logic        push, pop;
  logic [2:0]  wr_pos;
  logic [2:0]  used_ones;
  logic [2:0]  remaining;
  logic [2:0]  idx;
  logic [2:0]  pick;
  logic [2:0]  zero_seen;
  logic [6:0]  used_marked;
  logic [15:0] lfsr_step;

  assign push   = (count_reg < DEPTH_Q);
  assign pop    = spawn_req && (count_reg != 3'd0);
  // With a simultaneous pop the queue shifts first, so the tail slot moves down one.
  assign wr_pos = count_reg - {2'b00, pop};

  // Bag selection: idx-th unused code, counting unused codes from the LSB.
  always_comb begin
    used_ones = 3'd0;
    for (int i = 0; i < 7; i++) begin
      used_ones = used_ones + {2'b00, used_reg[i]};
    end
    // The mask is cleared when it fills, so remaining is always 1..7.
    remaining = 3'd7 - used_ones;
    idx       = 3'(lfsr_reg[7:0] % {5'd0, remaining});

    pick      = 3'd0;
    zero_seen = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!used_reg[i]) begin
        if (zero_seen == idx) begin
          pick = 3'(i);
        end
        zero_seen = zero_seen + 3'd1;
      end
    end
  end

  // FIFO slots: optional shift toward the head, then optional write at wr_pos.
  genvar gi;
  generate
    for (gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_slot
      logic [2:0] shifted;
      if (gi + 1 < PREVIEW_DEPTH) begin : g_mid
        assign shifted = pop ? fifo_reg[gi+1] : fifo_reg[gi];
      end else begin : g_last
        assign shifted = pop ? 3'd0 : fifo_reg[gi];
      end
      assign fifo_next[gi] = (push && (wr_pos == 3'(gi))) ? pick : shifted;

      always_ff @(posedge game_clk) begin
        if (reset) begin
          fifo_reg[gi] <= 3'd0;
        end else begin
          fifo_reg[gi] <= fifo_next[gi];
        end
      end
    end
  endgenerate

  // Next-state logic for the LFSR, bag, counters and status FSM.
  always_comb begin
    lfsr_step        = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    lfsr_step[15]    = lfsr_step[15] ^ entropy;
    lfsr_next        = (lfsr_step == 16'h0000) ? 16'h0001 : lfsr_step;

    used_marked      = used_reg | (7'b000_0001 << pick);
    used_next        = used_reg;
    if (push) begin
      used_next = (used_marked == 7'h7F) ? 7'h00 : used_marked;
    end

    count_next       = 3'(count_reg + {2'b00, push} - {2'b00, pop});
    piece_count_next = piece_count_reg + {15'd0, pop};
    underflow_next   = underflow_reg | (spawn_req && (count_reg == 3'd0));

    state_next       = state_reg;
    case (state_reg)
      FILL:    if (count_next == DEPTH_Q) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_reg       <= FILL;
      lfsr_reg        <= SEED_EFF;
      used_reg        <= 7'h00;
      count_reg       <= 3'd0;
      piece_count_reg <= 16'd0;
      underflow_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= lfsr_next;
      used_reg        <= used_next;
      count_reg       <= count_next;
      piece_count_reg <= piece_count_next;
      underflow_reg   <= underflow_next;
    end
  end

  // Outputs are decoded from registers only.
  assign piece_valid          = (count_reg != 3'd0);
  assign queue_count          = count_reg;
  assign piece_count          = piece_count_reg;
  assign underflow            = underflow_reg;
  assign next_piece_type      = (count_reg >= 3'd2) ? fifo_reg[1] : 3'd0;
  assign new_piece.piece_type = tetris_pkg::piece_type_t'(piece_valid ? fifo_reg[0] : 3'd0);
  assign new_piece.x          = SPAWN_X;
  assign new_piece.y          = SPAWN_Y;
  assign new_piece.rotation   = tetris_pkg::ROT_0;

endmodule

// File: tb/tb_piece_spawner.sv
// ---------------------------------------------------------------------------
// tb_piece_spawner: self-checking bench for piece_spawner.
//   A queue-based reference model (bag as a list of unused codes, FIFO as a
//   queue, LFSR in plain integer arithmetic) is stepped every clock and
//   compared with every DUT output; directed scenarios cover the start-up
//   sequence, bag property, full+pop, reset replay, entropy and underflow,
//   followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_piece_spawner;
  import tetris_pkg::*;

  localparam int          DEPTH  = 3;
  localparam logic [15:0] SEED_V = 16'h0001;

  logic          game_clk = 1'b0;
  logic          reset = 1'b1;
  logic          spawn_req = 1'b0;
  logic          entropy = 1'b0;
  active_piece_t new_piece;
  logic          piece_valid;
  logic [2:0]    next_piece_type;
  logic [2:0]    queue_count;
  logic [15:0]   piece_count;
  logic          underflow;

  piece_spawner #(.PREVIEW_DEPTH(DEPTH), .SEED(SEED_V)) dut (
    .game_clk        (game_clk),
    .reset           (reset),
    .spawn_req       (spawn_req),
    .entropy         (entropy),
    .new_piece       (new_piece),
    .piece_valid     (piece_valid),
    .next_piece_type (next_piece_type),
    .queue_count     (queue_count),
    .piece_count     (piece_count),
    .underflow       (underflow)
  );

  always #5 game_clk = ~game_clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_lfsr;
  int m_bag[$];
  int m_fifo[$];
  int m_pc;
  int m_under;
  int pop_log[$];
  int ref0[$];

  function automatic void m_reset();
    m_lfsr  = (SEED_V == 16'h0000) ? 1 : int'(SEED_V);
    m_bag   = '{0, 1, 2, 3, 4, 5, 6};
    m_fifo  = {};
    m_pc    = 0;
    m_under = 0;
  endfunction

  function automatic void m_step(input bit r, input bit s, input bit e);
    bit do_push;
    int k;
    int pick;
    int t;
    if (r) begin
      m_reset();
      return;
    end
    do_push = (m_fifo.size() < DEPTH);
    k = 0;
    pick = 0;
    if (do_push) begin
      k    = (m_lfsr % 256) % m_bag.size();
      pick = m_bag[k];
    end
    if (s) begin
      if (m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        m_pc = (m_pc + 1) % 65536;
      end else begin
        m_under = 1;
      end
    end
    if (do_push) begin
      m_fifo.push_back(pick);
      m_bag.delete(k);
      if (m_bag.size() == 0) m_bag = '{0, 1, 2, 3, 4, 5, 6};
    end
    t = m_lfsr / 2;
    if (m_lfsr % 2 == 1) t = t ^ 'hB400;
    if (e) t = t ^ 'h8000;
    if (t == 0) t = 1;
    m_lfsr = t;
  endfunction

  task automatic compare_all(input string tag);
    int sz;
    sz = m_fifo.size();
    check_val({tag, ".valid"}, int'(piece_valid), (sz > 0) ? 1 : 0);
    check_val({tag, ".count"}, int'(queue_count), sz);
    check_val({tag, ".head"},  int'(new_piece.piece_type), (sz > 0) ? m_fifo[0] : 0);
    check_val({tag, ".next"},  int'(next_piece_type), (sz >= 2) ? m_fifo[1] : 0);
    check_val({tag, ".pcnt"},  int'(piece_count), m_pc);
    check_val({tag, ".uflow"}, int'(underflow), m_under);
    check_val({tag, ".x"},     int'(new_piece.x), 4);
    check_val({tag, ".y"},     int'(new_piece.y), 0);
    check_val({tag, ".rot"},   int'(new_piece.rotation), 0);
  endtask

  // One clock: drive inputs, step the model on the edge, compare on the far edge.
  task automatic cycle(input bit r, input bit s, input bit e, input string tag);
    reset     = r;
    spawn_req = s;
    entropy   = e;
    if (!r && s && piece_valid) begin
      pop_log.push_back(int'(new_piece.piece_type));
      $display("[TB] pop %0d type %0d", pop_log.size(), int'(new_piece.piece_type));
    end
    @(posedge game_clk);
    m_step(r, s, e);
    @(negedge game_clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, "rst");
    cycle(1'b1, 1'b0, 1'b0, "rst");
    check_val("rst.count", int'(queue_count), 0);
    check_val("rst.valid", int'(piece_valid), 0);
    check_val("rst.next",  int'(next_piece_type), 0);
    check_val("rst.pcnt",  int'(piece_count), 0);
    check_val("rst.uflow", int'(underflow), 0);
    check_val("rst.head",  int'(new_piece.piece_type), 0);
  endtask

  task automatic idle3(input bit e);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, e, "fill");
  endtask

  task automatic pop_run(input int n, input bit e);
    pop_log.delete();
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, e, "popr");
      cycle(1'b0, 1'b0, e, "popr");
    end
  endtask

  function automatic int bag_ok(input int q[$]);
    int mask;
    for (int g = 0; g + 7 <= q.size(); g += 7) begin
      mask = 0;
      for (int j = 0; j < 7; j++) begin
        if (q[g+j] < 0 || q[g+j] > 6) return 0;
        mask = mask | (1 << q[g+j]);
      end
      if (mask != 'h7F) return 0;
    end
    return 1;
  endfunction

  initial begin
    int exp_head;
    int differs;
    m_reset();

    // Reset state
    do_reset();

    // Deterministic start: heads 1, 0, 2
    cycle(1'b0, 1'b0, 1'b0, "start");
    check_val("start.valid1", int'(piece_valid), 1);
    check_val("start.count1", int'(queue_count), 1);
    cycle(1'b0, 1'b0, 1'b0, "start");
    cycle(1'b0, 1'b0, 1'b0, "start");
    check_val("start.count3", int'(queue_count), 3);
    check_val("start.head",   int'(new_piece.piece_type), 1);
    check_val("start.next",   int'(next_piece_type), 0);

    // Bag property over 70 pops
    pop_run(70, 1'b0);
    check_val("bag.n",    pop_log.size(), 70);
    check_val("bag.p0",   pop_log[0], 1);
    check_val("bag.p1",   pop_log[1], 0);
    check_val("bag.p2",   pop_log[2], 2);
    check_val("bag.pcnt", int'(piece_count), 70);
    check_val("bag.perm", bag_ok(pop_log), 1);
    ref0 = pop_log;

    // Full FIFO with a pop: 3 -> 2 -> 3, old index-1 entry becomes head
    cycle(1'b0, 1'b0, 1'b0, "full");
    check_val("full.count", int'(queue_count), 3);
    exp_head = m_fifo[1];
    cycle(1'b0, 1'b1, 1'b0, "fullpop");
    check_val("fullpop.count", int'(queue_count), 2);
    check_val("fullpop.head",  int'(new_piece.piece_type), exp_head);
    cycle(1'b0, 1'b0, 1'b0, "refill");
    check_val("refill.count", int'(queue_count), 3);

    // Reset mid-run replays the deterministic sequence
    do_reset();
    idle3(1'b0);
    pop_run(10, 1'b0);
    for (int i = 0; i < 10; i++) check_val("replay1", pop_log[i], ref0[i]);
    do_reset();
    idle3(1'b0);
    pop_run(10, 1'b0);
    for (int i = 0; i < 10; i++) check_val("replay2", pop_log[i], ref0[i]);

    // Entropy held high changes the sequence but keeps the bag property
    do_reset();
    idle3(1'b1);
    pop_run(70, 1'b1);
    differs = 0;
    for (int i = 0; i < 70; i++) if (pop_log[i] != ref0[i]) differs = 1;
    check_val("ent.differs", differs, 1);
    check_val("ent.perm",    bag_ok(pop_log), 1);

    // Underflow on the first cycle after reset release
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, "uflow");
    check_val("uflow.flag",  int'(underflow), 1);
    check_val("uflow.pcnt",  int'(piece_count), 0);
    check_val("uflow.count", int'(queue_count), 1);
    cycle(1'b0, 1'b0, 1'b0, "uflow");
    check_val("uflow.sticky", int'(underflow), 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 2), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
